// File: rtl/spi_cmd_slave.sv
// spi_cmd_slave: SPI mode-0 command receiver for the pulse-generator register file.
// It turns MOSI bytes into register writes, immediate commands, and register reads
// that are returned on MISO. sclk, cs_n and mosi are asynchronous to clk_in.
`timescale 1ns/1ps

module spi_cmd_slave #(
  parameter int DATA_BYTES  = 2,
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    clk_in,
  input  logic                    sys_rst_n,
  input  logic                    sclk,
  input  logic                    cs_n,
  input  logic                    mosi,
  output logic                    miso,
  output logic                    reg_wr_en,
  output logic [ADDR_W-1:0]       reg_addr,
  output logic [8*DATA_BYTES-1:0] reg_wdata,
  input  logic [8*DATA_BYTES-1:0] rd_data,
  output logic                    cmd_valid,
  output logic [5:0]              cmd_code,
  output logic                    frame_err
);

  localparam int W  = 8 * DATA_BYTES;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    LAST_BYTE  = 3'(DATA_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WR_PAY = 2'd1,
    RD_PAY = 2'd2
  } state_t;

  // synchroniser and edge-detect registers
  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2;
  logic mosi_s1, mosi_s2;
  logic sclk_rise, sclk_fall;

  // deserialiser
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] byte_data;
  logic       byte_strobe;

  // frame decoder
  state_t          state;
  logic [2:0]      byte_cnt;
  logic [TW-1:0]   timer;
  logic [W-1:0]    pay_acc;
  logic [W-1:0]    wr_word;
  logic [W-1:0]    rd_swapped;
  logic [W-1:0]    tx_shift;
  logic            rd_load;
  logic            rise_seen;
  logic            timeout_hit;

  // Bring the SPI pins into the clk_in domain; cs_n idles deasserted.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= cs_n;
      cs_s2   <= cs_s1;
      mosi_s1 <= mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  assign sclk_rise   = sclk_s2 & ~sclk_d;
  assign sclk_fall   = ~sclk_s2 & sclk_d;
  assign timeout_hit = (timer == TIMER_LAST);

  // Shift in MSB-first bits on SCLK rising edges and emit one strobe per full byte.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      byte_data   <= 8'd0;
      byte_strobe <= 1'b0;
    end else begin
      byte_strobe <= 1'b0;
      if (cs_s2) begin
        bit_cnt <= 3'd0;
      end else if (sclk_rise) begin
        rx_shift <= {rx_shift[5:0], mosi_s2};
        if (bit_cnt == 3'd7) begin
          byte_data   <= {rx_shift, mosi_s2};
          byte_strobe <= 1'b1;
          bit_cnt     <= 3'd0;
        end else begin
          bit_cnt <= bit_cnt + 3'd1;
        end
      end
    end
  end

  // Merge the incoming payload byte into its little-endian slot of the write word.
  always_comb begin
    wr_word = pay_acc;
    wr_word[8*byte_cnt +: 8] = byte_data;
  end

  // Reorder the read word so byte 0 leaves first when shifting out from the top bit.
  always_comb begin
    rd_swapped = '0;
    for (int i = 0; i < DATA_BYTES; i++) begin
      rd_swapped[8*(DATA_BYTES-1-i) +: 8] = rd_data[8*i +: 8];
    end
  end

  // Frame decoder: opcode dispatch, payload collection, read shifting and timeout.
  always_ff @(posedge clk_in or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      byte_cnt  <= 3'd0;
      timer     <= '0;
      pay_acc   <= '0;
      tx_shift  <= '0;
      rd_load   <= 1'b0;
      rise_seen <= 1'b0;
      miso      <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      cmd_valid <= 1'b0;
      cmd_code  <= 6'd0;
      frame_err <= 1'b0;
    end else begin
      reg_wr_en <= 1'b0;
      cmd_valid <= 1'b0;
      frame_err <= 1'b0;
      rd_load   <= 1'b0;
      case (state)
        IDLE: begin
          timer <= '0;
          miso  <= 1'b0;
          if (byte_strobe) begin
            if (byte_data[7]) begin
              reg_addr <= byte_data[ADDR_W-1:0];
              byte_cnt <= 3'd0;
              pay_acc  <= '0;
              state    <= WR_PAY;
            end else if (byte_data[6]) begin
              reg_addr <= byte_data[ADDR_W-1:0];
              byte_cnt <= 3'd0;
              rd_load  <= 1'b1;
              state    <= RD_PAY;
            end else begin
              cmd_code  <= byte_data[5:0];
              cmd_valid <= 1'b1;
            end
          end
        end

        WR_PAY: begin
          if (byte_strobe) begin
            timer <= '0;
            if (byte_cnt == LAST_BYTE) begin
              reg_wdata <= wr_word;
              reg_wr_en <= 1'b1;
              state     <= IDLE;
            end else begin
              pay_acc  <= wr_word;
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (timeout_hit) begin
            frame_err <= 1'b1;
            timer     <= '0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        RD_PAY: begin
          // Only a falling edge that follows a host sampling edge advances the bit,
          // so the trailing fall of the opcode byte never skips the first bit.
          if (rd_load) begin
            miso      <= rd_swapped[W-1];
            tx_shift  <= rd_swapped << 1;
            rise_seen <= 1'b0;
          end else begin
            if (sclk_rise && !cs_s2) begin
              rise_seen <= 1'b1;
            end
            if (sclk_fall && rise_seen) begin
              miso      <= tx_shift[W-1];
              tx_shift  <= tx_shift << 1;
              rise_seen <= 1'b0;
            end
          end
          if (byte_strobe) begin
            timer <= '0;
            if (byte_cnt == LAST_BYTE) begin
              miso  <= 1'b0;
              state <= IDLE;
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end else if (timeout_hit) begin
            frame_err <= 1'b1;
            timer     <= '0;
            miso      <= 1'b0;
            state     <= IDLE;
          end else begin
            timer <= timer + 1'b1;
          end
        end

        default: begin
          state <= IDLE;
          miso  <= 1'b0;
        end
      endcase
    end
  end

endmodule
